// File: rtl/dual_slope_pkg.sv
// dual_slope_pkg: shared state encoding and default parameters for the dual-slope ADC controller
package dual_slope_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, INTEGRATE, DEINT, DONE} dual_slope_state_t;
  localparam int CNT_W_DEF = 12;
  localparam int INT_CYCLES_DEF = 2048;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/dual_slope_if.sv
// dual_slope_if: fsm_in agent bus between the conversion controller (slave) and its driver (master)
// Signals: comp_i, analog_ready_i, trigger_i, interrupt_clear_i, deintegrate_i toward the controller;
//   interrupt_o, az_o, int_o, ref_o, busy_o, overflow_o, result_o[CNT_W] back from it.
interface dual_slope_if import dual_slope_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) ();
  logic             comp_i;
  logic             analog_ready_i;
  logic             trigger_i;
  logic             interrupt_clear_i;
  logic             deintegrate_i;
  logic             interrupt_o;
  logic             az_o;
  logic             int_o;
  logic             ref_o;
  logic             busy_o;
  logic             overflow_o;
  logic [CNT_W-1:0] result_o;
  modport slave (
    input  comp_i, analog_ready_i, trigger_i, interrupt_clear_i, deintegrate_i,
    output interrupt_o, az_o, int_o, ref_o, busy_o, overflow_o, result_o
  );
  modport master (
    output comp_i, analog_ready_i, trigger_i, interrupt_clear_i, deintegrate_i,
    input  interrupt_o, az_o, int_o, ref_o, busy_o, overflow_o, result_o
  );
endinterface

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing an asynchronous bit into the clk_i domain
// Ports: clk_i, rst_i (sync, active-high, clears the chain), d_i async input, q_o synchronized output.
module sync_bit import dual_slope_pkg::*; #(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i)
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/dual_slope_ctrl.sv
// dual_slope_ctrl: dual-slope ADC sequencer (auto-zero, integrate, timed de-integrate, sticky interrupt)
// Ports: clk_i, rst_i (sync, active-high); bus (dual_slope_if.slave) with comparator and handshake
//   inputs, switch controls az/int/ref, busy, overflow, result and interrupt outputs.
// Build option DUAL_SLOPE_INT_TIMER_EN: INTEGRATE lasts INT_CYCLES clocks from an internal timer;
//   without it INTEGRATE ends on deintegrate_i.
module dual_slope_ctrl import dual_slope_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int INT_CYCLES  = INT_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic         clk_i,
  input logic         rst_i,
  dual_slope_if.slave bus
);
  if (INT_CYCLES < 1 || INT_CYCLES > 2**CNT_W || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("dual_slope_ctrl: parameter out of range");
  end
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef DUAL_SLOPE_INT_TIMER_EN
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_CYCLES - 1);
  logic unused_deint;
  assign unused_deint = bus.deintegrate_i;
`endif
  dual_slope_state_t state_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, res_q, res_d;
  logic              ovf_q, ovf_d, az_q, int_q, ref_q, busy_q, irq_q, comp_s;
  sync_bit #(.STAGES(SYNC_STAGES)) u_comp_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.comp_i),
    .q_o   (comp_s)
  );
  always_comb begin
    st_d  = state_q;
    cnt_d = cnt_q;
    res_d = res_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE:      if (bus.trigger_i) st_d = WAIT_RDY;
      WAIT_RDY:  if (bus.analog_ready_i) begin
        st_d  = INTEGRATE;
        cnt_d = '0;
      end
`ifdef DUAL_SLOPE_INT_TIMER_EN
      INTEGRATE: if (cnt_q == INT_LAST) begin
        st_d  = DEINT;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
`else
      INTEGRATE: if (bus.deintegrate_i) begin
        st_d  = DEINT;
        cnt_d = '0;
      end
`endif
      DEINT: if (!comp_s) begin
        st_d  = DONE;
        res_d = cnt_q;
        ovf_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        st_d  = DONE;
        res_d = CNT_MAX;
        ovf_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  // Switch and status flops are loaded from the next state so they change with the state itself.
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      az_q    <= 1'b1;
      int_q   <= 1'b0;
      ref_q   <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= st_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      az_q    <= st_d inside {IDLE, WAIT_RDY};
      int_q   <= st_d == INTEGRATE;
      ref_q   <= st_d == DEINT;
      busy_q  <= st_d != IDLE;
      irq_q   <= (state_q == DONE) || (irq_q && !bus.interrupt_clear_i);
    end
  assign bus.az_o        = az_q;
  assign bus.int_o       = int_q;
  assign bus.ref_o       = ref_q;
  assign bus.busy_o      = busy_q;
  assign bus.interrupt_o = irq_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.result_o    = res_q;
endmodule

// File: tb/tb_dual_slope_ctrl.sv
// tb_dual_slope_ctrl: scoreboard bench for dual_slope_ctrl (CNT_W=6, INT_CYCLES=16, SYNC_STAGES=2)
module tb_dual_slope_ctrl;
  localparam int CNT_W = 6;
  localparam int INT_CYCLES = 16;
  localparam int SS = 2;
`ifdef DUAL_SLOPE_INT_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  typedef struct {int res; int ovf; int int_len; int ref_len;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dual_slope_if #(.CNT_W(CNT_W)) bus ();
  dual_slope_ctrl #(.CNT_W(CNT_W), .INT_CYCLES(INT_CYCLES), .SYNC_STAGES(SS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int irq_seen = 0;
  int int_run = 0, ref_run = 0, int_last = 0, ref_last = 0;
  logic int_p = 1'b0, ref_p = 1'b0, irq_p = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("onehot_switches", int'(int'(bus.az_o) + int'(bus.int_o) + int'(bus.ref_o) > 1), 0);
    if (bus.int_o) int_run++;
    else if (int_p) begin
      int_last = int_run;
      int_run = 0;
      chk("ref_after_int", bus.ref_o, 1);
    end
    if (bus.ref_o) ref_run++;
    else if (ref_p) begin
      ref_last = ref_run;
      ref_run = 0;
    end
    if (bus.interrupt_o && !irq_p) begin
      irq_seen++;
      chk("irq_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", bus.result_o, e.res);
        chk("overflow", bus.overflow_o, e.ovf);
        chk("int_len", int_last, e.int_len);
        chk("ref_len", ref_last, e.ref_len);
      end
    end
    int_p = bus.int_o;
    ref_p = bus.ref_o;
    irq_p = bus.interrupt_o;
  end

  task automatic start_to_deint(int pulse, bit trig_busy);
    int n;
    bus.comp_i = 1'b1;
    bus.trigger_i = 1'b1;
    cyc();
    bus.trigger_i = 1'b0;
    chk("trig_busy", bus.busy_o, 1);
    chk("trig_az", bus.az_o, 1);
    cyc(2);
    chk("wait_rdy_hold", bus.int_o, 0);
    bus.analog_ready_i = 1'b1;
    cyc();
    bus.analog_ready_i = 1'b0;
    chk("rdy_int", bus.int_o, 1);
    if (trig_busy) bus.trigger_i = 1'b1;
    if (pulse > 1) cyc(pulse - 1);
    bus.deintegrate_i = 1'b1;
    cyc();
    bus.deintegrate_i = 1'b0;
    bus.trigger_i = 1'b0;
    for (n = 0; n < 200 && !bus.ref_o; n++) cyc();
    chk("deint_start", bus.ref_o, 1);
  endtask

  task automatic convert(int pulse, int comp_n, int ex_res, int ex_ovf, bit clr_done, bit trig_busy);
    exp_t e;
    int n;
    e.res = ex_res;
    e.ovf = ex_ovf;
    e.int_len = TIMER ? INT_CYCLES : pulse;
    e.ref_len = comp_n < 0 ? 2**CNT_W : comp_n + SS + 1;
    sb.push_back(e);
    start_to_deint(pulse, trig_busy);
    if (comp_n >= 0) begin
      cyc(comp_n);
      bus.comp_i = 1'b0;
    end
    for (n = 0; n < 200 && !(bus.busy_o && !bus.ref_o); n++) cyc();
    chk("done_state", int'(bus.busy_o && !bus.ref_o && !bus.az_o && !bus.int_o), 1);
    chk("done_irq_low", bus.interrupt_o, 0);
    bus.interrupt_clear_i = clr_done;
    cyc();
    bus.interrupt_clear_i = 1'b0;
    bus.comp_i = 1'b0;
    chk("irq_set", bus.interrupt_o, 1);
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_az", bus.az_o, 1);
    bus.interrupt_clear_i = 1'b1;
    cyc();
    bus.interrupt_clear_i = 1'b0;
    chk("irq_clear", bus.interrupt_o, 0);
    chk("result_hold", bus.result_o, ex_res);
  endtask

  initial begin
    int bad;
    bus.comp_i = 1'b0;
    bus.analog_ready_i = 1'b0;
    bus.trigger_i = 1'b0;
    bus.interrupt_clear_i = 1'b0;
    bus.deintegrate_i = 1'b0;
    rst = 1'b1;
    cyc(2);
    chk("rst_az", bus.az_o, 1);
    chk("rst_int", bus.int_o, 0);
    chk("rst_ref", bus.ref_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_irq", bus.interrupt_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    chk("rst_result", bus.result_o, 0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      cyc();
      if (bus.busy_o || !bus.az_o) bad++;
    end
    chk("idle_100", bad, 0);
    convert(16, 40, 40 + SS, 0, 1'b1, 1'b0);
    convert(16, -1, 63, 1, 1'b0, 1'b1);
    cyc(5);
    chk("no_retrigger", bus.busy_o, 0);
    chk("irq_count", irq_seen, 2);
    convert(TIMER ? 5 : 25, 10, 10 + SS, 0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_result_clear", bus.result_o, 0);
    start_to_deint(16, 1'b0);
    cyc(3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.comp_i = 1'b0;
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_az", bus.az_o, 1);
    chk("abort_ref", bus.ref_o, 0);
    chk("abort_irq", bus.interrupt_o, 0);
    chk("abort_result", bus.result_o, 0);
    cyc(10);
    chk("abort_no_irq", bus.interrupt_o, 0);
    chk("irq_total", irq_seen, 3);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dual_slope_ctrl.md
# dual_slope_ctrl

Conversion controller for the dual-slope integrating ADC; it is the DUT-side endpoint of the fsm_in agent bus. It consumes comp_i, analog_ready_i, trigger_i, interrupt_clear_i and deintegrate_i, and sequences the analog front end through auto-zero, fixed-time integrate and timed de-integrate phases. It counts the de-integrate time into a result register and raises a sticky interrupt_o on completion.

## Interface
- CNT_W, 12: de-integrate counter and result width
- INT_CYCLES, 2048: integrate-phase length in clocks; used only with the internal timer; range 1..2^CNT_W
- SYNC_STAGES, 2: synchronizer depth for comp_i; minimum 2
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- comp_i  in  1  comparator output, asynchronous; 1 = integrator above zero
- analog_ready_i  in  1  front end settled (level)
- trigger_i  in  1  start-conversion request (level, sampled)
- interrupt_clear_i  in  1  clears interrupt_o
- deintegrate_i  in  1  external end-of-integrate strobe; used only without the internal timer
- interrupt_o  out  1  sticky conversion-done flag
- az_o  out  1  auto-zero switch (integrator discharge)
- int_o  out  1  input-to-integrator switch
- ref_o  out  1  reference-to-integrator switch
- busy_o  out  1  conversion in progress
- overflow_o  out  1  last conversion saturated
- result_o  out  CNT_W  last de-integrate count

## Operation
- States: IDLE, WAIT_RDY, INTEGRATE, DEINT, DONE.
- IDLE: az_o=1. trigger_i=1 -> WAIT_RDY. A trigger is accepted even while interrupt_o is pending.
- WAIT_RDY: az_o=1. analog_ready_i=1 -> INTEGRATE; the phase counter clears.
- INTEGRATE: int_o=1.
  - With the internal timer, the block stays exactly INT_CYCLES cycles, then goes to DEINT.
  - Without it, deintegrate_i=1 -> DEINT; the first integrate cycle already honours the strobe.
- DEINT: ref_o=1. The counter starts at 0 on entry.
  - Each cycle with comp_s=1 (synchronized comp_i) increments the counter.
  - The first cycle with comp_s=0 latches the counter into result_o, clears overflow_o and moves to DONE.
  - If the counter equals 2^CNT_W-1 with comp_s still 1, result_o is set to all ones, overflow_o is set, and the state moves to DONE.
- DONE: one cycle, all switches off. Sets interrupt_o, then goes to IDLE.
- At most one of az_o/int_o/ref_o is high in any cycle.
- busy_o=1 in every state except IDLE.
- trigger_i is ignored while busy_o=1.
- interrupt_o is cleared by interrupt_clear_i. If a set (DONE) and a clear occur in the same cycle, the set wins.
- analog_ready_i dropping mid-conversion is ignored. Only rst_i aborts a conversion.
- Reset mid-conversion: the state returns to IDLE, the conversion is discarded and no interrupt is raised.

## Timing
- Reset values: state IDLE, az_o=1, int_o=0, ref_o=0, busy_o=0, interrupt_o=0, overflow_o=0, result_o=0, synchronizer flops cleared to 0.
- All outputs are registered.
- trigger_i high at edge N: WAIT_RDY and busy_o=1 from N+1.
- analog_ready_i high at edge M (in WAIT_RDY): int_o=1 from M+1.
- comp_i latency to the FSM is SYNC_STAGES cycles. The result therefore includes SYNC_STAGES cycles of comparator delay; software subtracts it.
- interrupt_o rises the cycle after DONE. result_o and overflow_o are valid no later than interrupt_o.
- Minimum trigger-to-interrupt time: 1 + 1 + INT_CYCLES + (count+1) + 1 + 1 cycles.

## Configuration
- DUAL_SLOPE_INT_TIMER_EN defined: the internal INT_CYCLES timer ends INTEGRATE and deintegrate_i is ignored.
- DUAL_SLOPE_INT_TIMER_EN undefined: no integrate timer is synthesized, and INTEGRATE ends on deintegrate_i=1.
  - In this build the integrate phase has no upper bound.

## Structure
- Shared package dual_slope_pkg holds the state enum typedef (dual_slope_state_t) and default parameter constants (CNT_W_DEF, INT_CYCLES_DEF, SYNC_STAGES_DEF).
- The single sub-module is sync_bit: a SYNC_STAGES-deep flop chain with synchronous reset, instantiated for comp_i. Everything else lives in dual_slope_ctrl.

## Test plan
- Reset, then idle: az_o=1, busy_o=0, interrupt_o=0, result_o=0. trigger_i held at 0 for 100 cycles -> state stays IDLE.
- Normal conversion (timer build, INT_CYCLES=16): trigger, ready, comp_i held 1 for 40 cycles of DEINT -> int_o high exactly 16 cycles, result_o=40+SYNC_STAGES, interrupt_o=1, overflow_o=0.
- Overflow (CNT_W=6): comp_i stuck at 1 -> result_o=63, overflow_o=1, interrupt_o=1, ref_o high 64 cycles.
- Clear versus set: interrupt_clear_i asserted in the DONE cycle -> interrupt_o=1. A clear one cycle later -> interrupt_o=0.
- Trigger while busy, plus reset mid-DEINT: a second trigger in INTEGRATE is ignored, giving one interrupt only. rst_i in DEINT -> IDLE next cycle, interrupt_o=0, result_o unchanged at 0.
- Non-timer build: deintegrate_i pulsed 25 cycles after int_o rises -> int_o high exactly 25 cycles, then ref_o=1 the next cycle.
